// File: rtl/fuzz_sig_pkg.sv
// Shared types and MISR arithmetic for the signature unloader and its harness models.
package fuzz_sig_pkg;

  localparam int          DEF_SIG_W = 32;
  localparam logic [31:0] DEF_POLY  = 32'h04C11DB7;
  localparam logic [31:0] DEF_SEED  = 32'hFFFFFFFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    UNLOAD  = 2'd2
  } state_t;

  // One MISR clock: shift left, reduce by the polynomial, then absorb the folded sample.
  function automatic logic [DEF_SIG_W-1:0] misr_step(input logic [DEF_SIG_W-1:0] misr,
                                                     input logic [DEF_SIG_W-1:0] folded);
    return {misr[DEF_SIG_W-2:0], 1'b0} ^ (misr[DEF_SIG_W-1] ? DEF_POLY : '0) ^ folded;
  endfunction

endpackage

// File: rtl/fuzz_xor_fold.sv
// Combinational XOR fold of a wide bus into SIG_W bits; the top chunk is zero-padded.
module fuzz_xor_fold #(
  parameter int Y_W   = 386,
  parameter int SIG_W = 32
) (
  input  logic [Y_W-1:0]   y,
  output logic [SIG_W-1:0] folded
);

  localparam int NCH = (Y_W + SIG_W - 1) / SIG_W;

  logic [NCH*SIG_W-1:0]      y_pad;
  logic [NCH:0][SIG_W-1:0]   acc;

  assign y_pad  = (NCH*SIG_W)'(y);
  assign acc[0] = '0;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_chunk
    assign acc[gi+1] = acc[gi] ^ y_pad[gi*SIG_W +: SIG_W];
  end

  assign folded = acc[NCH];

endmodule

// File: rtl/fuzz_sig_unloader.sv
// Compacts N samples of a wide result bus into a MISR signature and streams it out MSB byte first.
module fuzz_sig_unloader
  import fuzz_sig_pkg::*;
#(
  parameter int               Y_W   = 386,
  parameter int               SIG_W = 32,
  parameter int               OUT_W = 8,
  parameter int               CNT_W = 16,
  parameter logic [SIG_W-1:0] POLY  = SIG_W'(DEF_POLY),
  parameter logic [SIG_W-1:0] SEED  = SIG_W'(DEF_SEED)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [Y_W-1:0]   y,
  input  logic             start,
  input  logic [CNT_W-1:0] num_cycles,
  output logic             busy,
  output logic             done,
  output logic [OUT_W-1:0] sig_data,
  output logic             sig_valid,
  input  logic             sig_ready,
  output logic             sig_last
);

  localparam int NBEATS = SIG_W / OUT_W;
  localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(NBEATS - 1);

  state_t                        state_reg;
  logic [SIG_W-1:0]              misr_reg;
  logic [CNT_W-1:0]              cnt_reg;
  logic [BEAT_W-1:0]             beat_reg;
  logic                          valid_reg;
  logic                          done_reg;
  logic [SIG_W-1:0]              folded;
  logic [NBEATS-1:0][OUT_W-1:0]  beat_bytes;

  fuzz_xor_fold #(
    .Y_W   (Y_W),
    .SIG_W (SIG_W)
  ) u_fold (
    .y      (y),
    .folded (folded)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      misr_reg  <= '0;
      cnt_reg   <= '0;
      beat_reg  <= '0;
      valid_reg <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            misr_reg  <= SEED;
            cnt_reg   <= num_cycles;
            beat_reg  <= '0;
            state_reg <= (num_cycles != '0) ? CAPTURE : UNLOAD;
          end
        end
        CAPTURE: begin
          misr_reg <= {misr_reg[SIG_W-2:0], 1'b0} ^ (misr_reg[SIG_W-1] ? POLY : '0) ^ folded;
          cnt_reg  <= cnt_reg - 1'b1;
          if (cnt_reg == CNT_W'(1)) begin
            state_reg <= UNLOAD;
          end
        end
        UNLOAD: begin
          // One bubble cycle after entry before the first beat is presented.
          if (!valid_reg) begin
            valid_reg <= 1'b1;
          end else if (sig_ready) begin
            if (beat_reg == BEAT_LAST) begin
              state_reg <= IDLE;
              valid_reg <= 1'b0;
              done_reg  <= 1'b1;
              beat_reg  <= '0;
            end else begin
              beat_reg <= beat_reg + 1'b1;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  for (genvar gi = 0; gi < NBEATS; gi++) begin : g_beat
    assign beat_bytes[gi] = misr_reg[SIG_W-1-gi*OUT_W -: OUT_W];
  end

  assign busy      = (state_reg != IDLE);
  assign done      = done_reg;
  assign sig_valid = valid_reg;
  assign sig_data  = valid_reg ? beat_bytes[beat_reg] : '0;
  assign sig_last  = valid_reg && (beat_reg == BEAT_LAST);

endmodule

// File: tb/tb_fuzz_sig_unloader.sv
// Randomized bench for fuzz_sig_unloader against a bit-level signature model with a beat scoreboard.
module tb_fuzz_sig_unloader;
  import fuzz_sig_pkg::*;

  localparam int Y_W   = 386;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [Y_W-1:0]   y = '0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] num_cycles = '0;
  logic             sig_ready = 1'b0;
  logic             busy, done, sig_valid, sig_last;
  logic [7:0]       sig_data;

  int errors = 0;
  int checks = 0;
  int dones_pending = 0;
  int dones_seen = 0;
  int beats_seen = 0;
  logic [8:0] exp_q[$];
  logic       stall_prev = 1'b0;
  logic [8:0] stall_val = '0;

  fuzz_sig_unloader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .y          (y),
    .start      (start),
    .num_cycles (num_cycles),
    .busy       (busy),
    .done       (done),
    .sig_data   (sig_data),
    .sig_valid  (sig_valid),
    .sig_ready  (sig_ready),
    .sig_last   (sig_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: bit b of y lands on signature bit b mod 32; the MISR is a plain shift with polynomial reduction.
  function automatic logic [31:0] model_fold(input logic [Y_W-1:0] v);
    logic [31:0] f = '0;
    for (int b = 0; b < Y_W; b++) if (v[b]) f[b % 32] = ~f[b % 32];
    return f;
  endfunction

  function automatic logic [31:0] model_step(input logic [31:0] m, input logic [31:0] f);
    logic [32:0] w = {m, 1'b0};
    if (w[32]) w[31:0] = w[31:0] ^ 32'h04C11DB7;
    return w[31:0] ^ f;
  endfunction

  function automatic logic [Y_W-1:0] rnd_y();
    logic [415:0] t;
    for (int w = 0; w < 13; w++) t[w*32 +: 32] = $urandom;
    return t[Y_W-1:0];
  endfunction

  // Per-cycle scoreboard check, taken on the falling edge.
  task automatic compare();
    logic [8:0] e;
    if (!rst_n) begin
      stall_prev = 1'b0;
      return;
    end
    if (stall_prev) chk("hold_stable", {sig_valid, sig_last, sig_data}, {1'b1, stall_val});
    if (sig_valid) chk("busy_with_valid", busy, 1'b1);
    if (sig_valid && sig_ready) begin
      if (exp_q.size() == 0) begin
        chk("beat_expected", 0, 1);
      end else begin
        e = exp_q.pop_front();
        chk("beat", {sig_last, sig_data}, e);
      end
      beats_seen++;
    end
    stall_prev = sig_valid && !sig_ready;
    stall_val  = {sig_last, sig_data};
    if (done) begin
      chk("done_expected", dones_pending > 0, 1);
      chk("done_queue_empty", exp_q.size(), 0);
      chk("busy_low_at_done", busy, 1'b0);
      if (dones_pending > 0) dones_pending--;
      dones_seen++;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    compare();
    @(posedge clk);
    #1;
  endtask

  // mode: 0 ready held high, 1 random ready, 2 ready low for 3 cycles while beat 1 is shown.
  task automatic run(input int n, input bit rand_y, input logic [Y_W-1:0] fixed_y,
                     input int mode, input bit extra_starts, input int abort_beats,
                     output logic [31:0] sig);
    logic [31:0]    m = 32'hFFFFFFFF;
    logic [Y_W-1:0] s;
    int budget = 0;
    int bp = 0;
    int d0 = dones_seen;
    int b0 = beats_seen;
    sig_ready  = (mode != 1) ? 1'b1 : 1'($urandom_range(0, 1));
    start      = 1'b1;
    num_cycles = CNT_W'(n);
    y          = rnd_y();
    tick();
    start = 1'b0;
    chk("busy_after_start", busy, 1'b1);
    chk("valid_low_after_start", sig_valid, 1'b0);
    for (int j = 0; j < n; j++) begin
      s = rand_y ? rnd_y() : fixed_y;
      y = s;
      m = model_step(m, model_fold(s));
      num_cycles = CNT_W'($urandom);
      if (mode == 1) sig_ready = 1'($urandom_range(0, 1));
      if (extra_starts && j == 1) start = 1'b1;
      tick();
      start = 1'b0;
    end
    chk("bubble_before_first_beat", sig_valid, 1'b0);
    y = rnd_y();
    for (int b = 0; b < 4; b++) exp_q.push_back({b == 3, m[31-8*b -: 8]});
    dones_pending++;
    sig = m;
    while (dones_seen == d0 && budget < 400) begin
      if (mode == 1) sig_ready = 1'($urandom_range(0, 1));
      if (mode == 2) begin
        if (beats_seen - b0 == 1 && bp < 3) begin
          sig_ready = 1'b0;
          bp++;
        end else begin
          sig_ready = 1'b1;
        end
      end
      if (extra_starts && sig_valid && sig_last && sig_ready) begin
        start = 1'b1;
        num_cycles = 16'd3;
      end
      if (abort_beats >= 0 && beats_seen - b0 == abort_beats) begin
        #2 rst_n = 1'b0;
        #1;
        chk("abort_outputs_zero", {busy, done, sig_valid, sig_last, sig_data}, '0);
        exp_q.delete();
        dones_pending = 0;
        tick();
        tick();
        chk("abort_no_done", dones_seen, d0);
        rst_n = 1'b1;
        tick();
        return;
      end
      tick();
      start = 1'b0;
      budget++;
    end
    if (budget >= 400) chk("run_timeout", 0, 1);
    if (mode == 0) chk("unload_cycles", budget, 6);
    if (mode == 2) chk("unload_cycles_bp", budget, 9);
    tick();
    tick();
    chk("idle_after_run", busy, 1'b0);
  endtask

  initial begin
    logic [31:0]    sig;
    logic [Y_W-1:0] v;
    logic [31:0]    a, f;

    #1;
    chk("reset_outputs", {busy, done, sig_valid, sig_last, sig_data}, '0);
    #20 rst_n = 1'b1;
    tick();
    chk("idle_outputs", {busy, done, sig_valid, sig_last, sig_data}, '0);

    // Pin the model and the shared package step against hand-computed values.
    chk("model_step_y0", model_step(32'hFFFFFFFF, model_fold('0)), 32'hFB3EE249);
    chk("pkg_step_y0", misr_step(32'hFFFFFFFF, 32'h0), 32'hFB3EE249);
    for (int i = 0; i < 4; i++) begin
      a = $urandom;
      f = $urandom;
      chk("pkg_vs_model", misr_step(a, f), model_step(a, f));
    end

    run(1, 1'b0, '0, 0, 1'b0, -1, sig);
    chk("sig_y0", sig, 32'hFB3EE249);
    run(0, 1'b0, '0, 0, 1'b0, -1, sig);
    chk("sig_n0", sig, 32'hFFFFFFFF);

    v = '0; v[0] = 1'b1;
    run(1, 1'b0, v, 0, 1'b0, -1, sig);
    chk("sig_bit0", sig, 32'hFB3EE248);
    v = '0; v[384] = 1'b1;
    run(1, 1'b0, v, 0, 1'b0, -1, sig);
    chk("sig_bit384", sig, 32'hFB3EE248);
    v = '0; v[0] = 1'b1; v[32] = 1'b1;
    run(1, 1'b0, v, 0, 1'b0, -1, sig);
    chk("sig_cancel", sig, 32'hFB3EE249);

    run(1, 1'b0, '0, 2, 1'b0, -1, sig);
    run(5, 1'b1, '0, 1, 1'b1, -1, sig);
    chk("single_done_pending", dones_pending, 0);

    run(3, 1'b1, '0, 0, 1'b0, 2, sig);
    run(1, 1'b0, '0, 0, 1'b0, -1, sig);
    chk("sig_after_abort", sig, 32'hFB3EE249);

    for (int r = 0; r < 15; r++) begin
      run($urandom_range(0, 12), 1'b1, '0, 1, 1'($urandom_range(0, 1)), -1, sig);
    end
    chk("final_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fuzz_sig_unloader.md
Name: fuzz_sig_unloader

Overview:
Receive-side companion to the fuzz DUT wrappers. It samples the wide packed result bus `y` of a generated top over a programmed number of clock cycles and compacts it into a 32-bit MISR signature. It then unloads the signature byte-serially over a valid/ready stream to the equivalence harness. Two netlists (RTL vs. synthesized) are judged equivalent when their unloaded signatures match.

Parameters:
- Y_W, 386, width of the sampled result bus (matches `y` of the DUT wrapper).
- SIG_W, 32, MISR/signature width; must be a multiple of OUT_W.
- OUT_W, 8, unload beat width.
- CNT_W, 16, width of the sample-count register.
- POLY, 32'h04C11DB7, MISR feedback polynomial.
- SEED, 32'hFFFFFFFF, MISR value loaded on start.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- y  in  Y_W  DUT result bus, sampled during CAPTURE.
- start  in  1  single-cycle request to begin a run; honoured only in IDLE.
- num_cycles  in  CNT_W  number of y samples; latched on accepted start.
- busy  out  1  high in CAPTURE and UNLOAD.
- done  out  1  one-cycle pulse after the final unload handshake.
- sig_data  out  OUT_W  signature beat, MSB byte first.
- sig_valid  out  1  beat valid.
- sig_ready  in  1  downstream accept.
- sig_last  out  1  high with the final beat (beat SIG_W/OUT_W-1).

Behaviour:
- Reset (async assert, sync release): state=IDLE, misr=0, cnt=0, beat=0.
  - All outputs are 0: busy, done, sig_valid, sig_last, sig_data.
- Fold function:
  - Split y into ceil(Y_W/SIG_W) chunks of SIG_W bits, chunk i = y[i*SIG_W +: SIG_W].
  - The top chunk is zero-padded above Y_W-1.
  - fold(y) = XOR of all chunks (13 chunks for the defaults).
- MISR step: misr_next = {misr[SIG_W-2:0],1'b0} ^ (misr[SIG_W-1] ? POLY : 0) ^ fold(y).
- IDLE:
  - On start=1 at edge k: misr<=SEED, cnt<=num_cycles.
  - If num_cycles!=0 go to CAPTURE; else go directly to UNLOAD with beat=0.
  - busy rises at k.
- CAPTURE:
  - At each edge: one MISR step on current y, cnt<=cnt-1.
  - The edge on which cnt==1 performs the last step and moves to UNLOAD.
  - The first y sampled is the one present at edge k+1; N samples are taken at edges k+1..k+N.
- UNLOAD:
  - sig_valid=1 from the cycle after entry (first beat visible after edge k+N+1).
  - sig_data = misr[SIG_W-1-beat*OUT_W -: OUT_W].
  - A beat completes on an edge with sig_valid&&sig_ready; beat<=beat+1.
  - sig_valid, sig_data and sig_last hold stable while sig_ready=0; there are no gaps between beats while sig_ready=1.
  - On completion of the last beat: state=IDLE, sig_valid=0, done=1 for exactly one cycle, busy=0 in that same cycle.
  - The misr register retains its value until the next start.
- Boundaries:
  - start outside IDLE is ignored; num_cycles changes outside IDLE are ignored.
  - start coincident with the final handshake is ignored; it is accepted only from the next cycle.
  - cnt never underflows.
  - Max run is 2^CNT_W-1 samples.
  - rst_n low mid-CAPTURE or mid-UNLOAD aborts immediately to the reset state; no done pulse is generated.

Decomposition:
- Package fuzz_sig_pkg:
  - state enum (IDLE, CAPTURE, UNLOAD);
  - default POLY/SEED constants;
  - function misr_step(misr, folded) shared with the harness reference model.
- One sub-module, fuzz_xor_fold: purely combinational Y_W->SIG_W XOR fold, parameterised by Y_W/SIG_W, with its own unit bench.
- The FSM, counter, MISR register and unload mux stay in the top.

Test Plan:
- y=0, num_cycles=1, sig_ready=1 -> beats FB,3E,E2,49 on 4 consecutive cycles, sig_last on 49, done pulse on the next cycle.
- num_cycles=0 -> no CAPTURE, beats FF,FF,FF,FF, done.
- Fold coverage, each with num_cycles=1 -> FB3EE248, FB3EE248 and FB3EE249 respectively:
  - y with only bit 0 set;
  - y with only bit 384 set (padded top chunk);
  - y with bits 0 and 32 set (cancel).
- Backpressure: sig_ready=0 for 3 cycles while beat 1 is presented -> sig_data=3E held stable, no beat lost, total order FB,3E,E2,49.
- Second start pulsed during CAPTURE and again on the final handshake cycle -> both ignored, a single done; num_cycles=5 with random y matches the pkg reference model.
- rst_n dropped mid-UNLOAD after beat 1 -> outputs 0 asynchronously, no done; a fresh run afterwards produces the correct signature.
